seg_scan_driver: RTL

- Downstream display stage for the traffic-light countdown timers.
- Takes two binary countdown values (0..99) and converts each to two BCD digits with a sequential converter.
- Drives a 4-digit, common-anode, time-multiplexed 7-segment display with anti-ghosting blanking and leading-zero suppression.
- Replaces ad-hoc per-value segment decoding in the timer block with one shared, glitch-free scanner.

---
 rtl/seg_pkg.sv | 33 +++
 rtl/bin2bcd_seq.sv | 55 +++++
 rtl/seg_scan_driver.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants and helpers for the 7-segment countdown display.
package seg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [6:0] VAL_MAX = 7'd99;

    // Active-low a..g,dp patterns; element 0 is the digit 0 pattern.
    localparam logic [9:0][7:0] SEG_DIGIT = {
        8'h09, 8'h01, 8'h1F, 8'h41, 8'h49,
        8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03
    };

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_LOAD
    } conv_state_e;

    // Clamp a 7-bit count to the two-digit range the display can show.
    function automatic logic [6:0] sat99(input logic [6:0] v);
        return (v > VAL_MAX) ? VAL_MAX : v;
    endfunction

    // Non-decimal codes fall back to blank rather than showing garbage.
    function automatic logic [7:0] seg_encode(input bcd_t d);
        return (d <= 4'd9) ? SEG_DIGIT[d] : SEG_BLANK;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 7-bit binary to two-digit BCD converter (add-3 / shift).
module bin2bcd_seq
    import seg_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start_i,
    input  logic [6:0] value_i,
    output bcd_t       tens_o,
    output bcd_t       ones_o,
    output logic       done_o
);

    // {tens, ones, binary} working register, shifted left once per step.
    logic [14:0] sr_q, sr_d;
    logic [2:0]  step_q;
    logic        run_q;
    logic        done_q;
    bcd_t        tens_adj, ones_adj;

    // One double-dabble step: correct each nibble, then shift.
    always_comb begin
        tens_adj = (sr_q[14:11] >= 4'd5) ? sr_q[14:11] + 4'd3 : sr_q[14:11];
        ones_adj = (sr_q[10:7]  >= 4'd5) ? sr_q[10:7]  + 4'd3 : sr_q[10:7];
        sr_d     = {tens_adj[2:0], ones_adj, sr_q[6:0], 1'b0};
    end

    // Load on start, then run exactly seven steps and flag completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q   <= '0;
            step_q <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else if (start_i) begin
            sr_q   <= {8'd0, value_i};
            step_q <= '0;
            run_q  <= 1'b1;
            done_q <= 1'b0;
        end else if (run_q) begin
            sr_q <= sr_d;
            if (step_q == 3'd6) begin
                run_q  <= 1'b0;
                done_q <= 1'b1;
            end else begin
                step_q <= step_q + 3'd1;
            end
        end
    end

    assign tens_o = sr_q[14:11];
    assign ones_o = sr_q[10:7];
    assign done_o = done_q;

endmodule

// File: rtl/seg_scan_driver.sv
// Two-channel countdown display: BCD conversion FSM plus a blanked,
// time-multiplexed scanner for a 4-digit common-anode 7-segment display.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500,
    parameter int LZ_BLANK  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            count_a,
    input  logic [6:0]            count_b,
    input  logic                  en_a,
    input  logic                  en_b,
    output logic [NUM_DIGITS-1:0] an,
    output logic [7:0]            seg,
    output logic                  busy
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam logic [SW-1:0] SLOT_MAX = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] BLANK_W  = SW'(BLANK_CYC);

    conv_state_e state_q;
    logic        pending_q, busy_q;
    logic [2:0]  shift_q;
    logic [6:0]  cap_a_q, cap_b_q;
    logic [6:0]  sat_a, sat_b;
    logic        trigger, start;

    // Display digits indexed by scan position: A ones, A tens, B ones, B tens.
    bcd_t [NUM_DIGITS-1:0] disp_q, disp_d;

    bcd_t tens_a, ones_a, tens_b, ones_b;
    logic done_a, done_b;

    logic [SW-1:0] slot_q, slot_d;
    logic [1:0]    dig_q, dig_d;
    logic [NUM_DIGITS-1:0] an_q;
    logic [7:0]    seg_q, digit_seg;
    bcd_t          digit_val;
    logic          digit_show;

    assign sat_a   = sat99(count_a);
    assign sat_b   = sat99(count_b);
    // Compare saturated values so an out-of-range input does not retrigger forever.
    assign trigger = pending_q || (sat_a != cap_a_q) || (sat_b != cap_b_q);
    assign start   = (state_q == ST_IDLE) && trigger;

    bin2bcd_seq u_conv_a (
        .clk     (clk),
        .reset   (reset),
        .start_i (start),
        .value_i (sat_a),
        .tens_o  (tens_a),
        .ones_o  (ones_a),
        .done_o  (done_a)
    );

    bin2bcd_seq u_conv_b (
        .clk     (clk),
        .reset   (reset),
        .start_i (start),
        .value_i (sat_b),
        .tens_o  (tens_b),
        .ones_o  (ones_b),
        .done_o  (done_b)
    );

    // Conversion control: capture, 7 shift cycles, then a single load cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pending_q <= 1'b1;
            busy_q    <= 1'b0;
            shift_q   <= '0;
            cap_a_q   <= '0;
            cap_b_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (trigger) begin
                        cap_a_q   <= sat_a;
                        cap_b_q   <= sat_b;
                        pending_q <= 1'b0;
                        busy_q    <= 1'b1;
                        shift_q   <= '0;
                        state_q   <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    if (shift_q == 3'd6) state_q <= ST_LOAD;
                    else                 shift_q <= shift_q + 3'd1;
                end
                ST_LOAD: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Display digits only move on LOAD, so the scan never sees partial results.
    always_comb begin
        disp_d = disp_q;
        if (state_q == ST_LOAD && done_a && done_b)
            disp_d = {tens_b, ones_b, tens_a, ones_a};
    end

    // Display digit registers.
    always_ff @(posedge clk) begin
        if (reset) disp_q <= '0;
        else       disp_q <= disp_d;
    end

    // Next slot/digit; digit advances when the slot counter wraps.
    always_comb begin
        slot_d = (slot_q == SLOT_MAX) ? '0 : slot_q + SW'(1);
        dig_d  = (slot_q == SLOT_MAX) ? dig_q + 2'd1 : dig_q;
    end

    // Segment pattern for the digit about to be shown, with enable and LZ blanking.
    always_comb begin
        digit_val  = disp_d[dig_d];
        digit_show = dig_d[1] ? en_b : en_a;
        if (!digit_show || (LZ_BLANK != 0 && dig_d[0] && digit_val == 4'd0))
            digit_seg = SEG_BLANK;
        else
            digit_seg = seg_encode(digit_val);
    end

    // Scanner and output registers; outputs track the post-edge slot state.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q <= '0;
            dig_q  <= '0;
            an_q   <= AN_OFF;
            seg_q  <= SEG_BLANK;
        end else begin
            slot_q <= slot_d;
            dig_q  <= dig_d;
            if (slot_d < BLANK_W) begin
                an_q  <= AN_OFF;
                seg_q <= SEG_BLANK;
            end else begin
                an_q  <= ~(NUM_DIGITS'(1) << dig_d);
                seg_q <= digit_seg;
            end
        end
    end

    assign an   = an_q;
    assign seg  = seg_q;
    assign busy = busy_q;

endmodule
